// File: rtl/dff_piso_tx_if.sv
// dff_piso_tx_if: load handshake and framed serial bit stream of the PISO transmitter
interface dff_piso_tx_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             frame_done;
    modport master (
        output load_valid, load_data,
        input  load_ready, ser_out, ser_valid, frame_start, frame_done
    );
    modport slave (
        input  load_valid, load_data,
        output load_ready, ser_out, ser_valid, frame_start, frame_done
    );
endinterface

// File: rtl/dff_piso_tx.sv
// dff_piso_tx: valid/ready loaded parallel-in/serial-out transmitter with framing strobes and inter-frame gap
module dff_piso_tx #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 1
) (
    input logic          clk,
    input logic          rst_sync,
    dff_piso_tx_if.slave tx
);
    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT   = CW'(WIDTH - 2);
    localparam logic [3:0]    GAP_LAST = 4'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_gap;
    logic             r_ser_out;
    logic             r_ser_valid;
    logic             r_frame_start;
    logic             r_frame_done;
    logic             w_last;
    logic             w_load;
    // r_shift holds the bits still to send; the bit on ser_out is already out of it
    always_comb begin
        w_last         = r_state == SHIFT && r_cnt == LAST;
        tx.load_ready  = !rst_sync && (r_state == IDLE || (GAP_CYCLES == 0 && w_last));
        w_load         = tx.load_valid && tx.load_ready;
        tx.ser_out     = r_ser_out;
        tx.ser_valid   = r_ser_valid;
        tx.frame_start = r_frame_start;
        tx.frame_done  = r_frame_done;
    end
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            r_state       <= IDLE;
            r_shift       <= '0;
            r_cnt         <= '0;
            r_gap         <= '0;
            r_ser_out     <= 1'b0;
            r_ser_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
        end else if (w_load) begin
            r_state       <= SHIFT;
            r_shift       <= MSB_FIRST ? tx.load_data << 1 : tx.load_data >> 1;
            r_cnt         <= '0;
            r_gap         <= '0;
            r_ser_out     <= MSB_FIRST ? tx.load_data[WIDTH-1] : tx.load_data[0];
            r_ser_valid   <= 1'b1;
            r_frame_start <= 1'b1;
            r_frame_done  <= 1'b0;
        end else if (r_state == SHIFT && !w_last) begin
            r_shift       <= MSB_FIRST ? r_shift << 1 : r_shift >> 1;
            r_cnt         <= r_cnt + 1'b1;
            r_ser_out     <= MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
            r_frame_start <= 1'b0;
            r_frame_done  <= r_cnt == PENULT;
        end else begin
            r_state       <= (w_last && GAP_CYCLES > 0) || (r_state == GAP && r_gap != GAP_LAST) ? GAP : IDLE;
            r_gap         <= r_state == GAP ? r_gap + 1'b1 : '0;
            r_ser_out     <= 1'b0;
            r_ser_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dff_piso_tx.sv
// tb_dff_piso_tx: randomized scoreboard bench over three width/order/gap configurations
module tb_dff_piso_tx;
    typedef struct {
        int   cyc;
        logic b;
        logic s;
        logic d;
    } exp_t;
    localparam int NC = 3;
    logic clk = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    for (genvar g = 0; g < NC; g++) begin : c
        localparam int          W  = g == 2 ? 5 : 8;
        localparam bit          M  = g != 1;
        localparam int          G  = g == 0 ? 3 : 0;
        localparam logic [31:0] D0 = g == 0 ? 32'hA5 : g == 1 ? 32'h01 : 32'h1A;
        localparam logic [31:0] D1 = g == 0 ? 32'hC3 : g == 1 ? 32'hFF : 32'h15;
        localparam logic [31:0] D2 = g == 0 ? 32'h5A : g == 1 ? 32'h00 : 32'h0F;
        logic        rst = 1'b1;
        exp_t        q[$];
        exp_t        e;
        int          x, busy, last, k;
        bit          mid, r, er, ev;
        logic [31:0] d;
        dff_piso_tx_if #(.WIDTH(W)) bus ();
        dff_piso_tx #(.WIDTH(W), .MSB_FIRST(M), .GAP_CYCLES(G)) dut (
            .clk     (clk),
            .rst_sync(rst),
            .tx      (bus)
        );
        // stimulus plus model of the ready window; captured words expand into expected bit slots
        initial begin
            busy = 0;
            last = -1;
            k = 0;
            mid = 0;
            bus.load_valid = 1'b0;
            bus.load_data = '0;
            for (int n = 0; n < 700; n++) begin
                @(posedge clk);
                #1;
                x = cyc;
                r = n < 2 || (n > 5 && $urandom_range(0, 79) == 0);
                if (g == 0 && k == 2 && !mid && x == last - W + 5) begin
                    r = 1;
                    mid = 1;
                end
                rst = r;
                d = k == 0 ? D0 : k == 1 ? D1 : k == 2 ? D2 : $urandom;
                if (!(x > busy || (G == 0 && x == last))) d = $urandom;
                bus.load_valid = (g == 1 && k < 3) || $urandom_range(0, 3) != 0;
                bus.load_data = d[W-1:0];
                @(negedge clk);
                er = !r && (x > busy || (G == 0 && x == last));
                tests++;
                if (bus.load_ready !== er) begin
                    fails++;
                    $display("FAIL cfg%0d load_ready cyc=%0d got=%b exp=%b", g, x, bus.load_ready, er);
                end
                if (r) begin
                    busy = x;
                    last = -1;
                    while (q.size() > 0 && q[q.size()-1].cyc > x) void'(q.pop_back());
                end else if (bus.load_valid && er) begin
                    for (int i = 0; i < W; i++)
                        q.push_back('{x + 1 + i, M ? d[W-1-i] : d[i], i == 0, i == W - 1});
                    last = x + W;
                    busy = x + W + G;
                    k++;
                end
            end
            rst = 1'b0;
            bus.load_valid = 1'b0;
            repeat (W + G + 4) @(negedge clk);
            tests++;
            if (q.size() != 0) begin
                fails++;
                $display("FAIL cfg%0d drain pending=%0d exp=0", g, q.size());
            end
            done_cnt++;
        end
        initial begin
            @(posedge clk);
            forever begin
                @(negedge clk);
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    tests++;
                    fails++;
                    $display("FAIL cfg%0d missing_bit slot=%0d now=%0d", g, q[0].cyc, cyc);
                    void'(q.pop_front());
                end
                ev = q.size() > 0 && q[0].cyc == cyc;
                tests++;
                if (ev && bus.ser_valid) begin
                    e = q.pop_front();
                    if ({bus.ser_out, bus.frame_start, bus.frame_done} !== {e.b, e.s, e.d}) begin
                        fails++;
                        $display("FAIL cfg%0d bit cyc=%0d got out/start/done=%b%b%b exp=%b%b%b", g, cyc,
                                 bus.ser_out, bus.frame_start, bus.frame_done, e.b, e.s, e.d);
                    end
                end else if (ev || {bus.ser_valid, bus.ser_out, bus.frame_start, bus.frame_done} !== 4'b0) begin
                    fails++;
                    if (ev) void'(q.pop_front());
                    $display("FAIL cfg%0d idle cyc=%0d got valid/out/start/done=%b%b%b%b exp_valid=%b", g, cyc,
                             bus.ser_valid, bus.ser_out, bus.frame_start, bus.frame_done, ev);
                end
            end
        end
    end
    initial begin
        for (int t = 0; t < 5000 && done_cnt < NC; t++) @(posedge clk);
        if (done_cnt < NC) begin
            tests++;
            fails++;
            $display("FAIL timeout done=%0d exp=%0d", done_cnt, NC);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dff_piso_tx.md
Name: dff_piso_tx

Overview:
- Parallel-in/serial-out transmitter built on registered (DFF) state.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clk on ser_out, with framing strobes.
- Drives the serial bit stream consumed by the team's flip-flop-based serial capture/shift chains.
- Acts as the producer end of that single-wire bit interface.

Parameters:
- WIDTH, 8, bits per frame; legal range 2..32.
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.
- GAP_CYCLES, 1, idle cycles forced between frames; legal range 0..15.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_sync  input  1  synchronous, active-high reset.
- load_valid  input  1  load_data is valid this cycle.
- load_ready  output  1  transmitter can accept a word this cycle.
- load_data  input  WIDTH  parallel word to transmit.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out carries a frame bit this cycle.
- frame_start  output  1  one-cycle pulse coincident with the first bit of a frame.
- frame_done  output  1  one-cycle pulse coincident with the last bit of a frame.

Behaviour:
- Interface: one clock domain, clk. Reset is synchronous and active-high, named rst_sync.
- All outputs are registered, except load_ready, which is decoded from registered state only (no combinational path from load_valid).
- Reset: while rst_sync is high at a rising edge, the following take effect on that edge:
  - state <= IDLE; shift register, bit counter and gap counter <= 0.
  - ser_out, ser_valid, frame_start and frame_done <= 0.
  - load_ready = 0 while rst_sync is high.
- Reset mid-frame aborts the frame immediately. No frame_done is produced, and the remaining bits are discarded.
- rst_sync has priority over every other input.

State machine (IDLE, SHIFT, GAP):
- IDLE:
  - load_ready = 1.
  - On load_valid & load_ready, capture load_data and go to SHIFT.
  - In the next cycle: ser_out = first bit, ser_valid = 1, frame_start = 1, bit counter = 0.
  - Latency from accepting edge to first bit: 1 cycle.
- SHIFT:
  - Each edge advances one bit and increments the bit counter.
  - Bit order is set by MSB_FIRST.
  - The cycle with bit counter = WIDTH-1 carries the last bit, with frame_done = 1.
  - frame_start and frame_done are both 1 only if WIDTH=1, which is illegal.
  - After the last bit: if GAP_CYCLES > 0, go to GAP; else go to IDLE.
- Back-to-back (GAP_CYCLES = 0):
  - load_ready is also 1 during the last-bit cycle of SHIFT.
  - A handshake there loads the next word, so its first bit follows the previous last bit with no idle cycle.
  - frame_start is then high in the cycle after frame_done.
- GAP:
  - Lasts exactly GAP_CYCLES cycles.
  - ser_valid = 0, ser_out = 0, load_ready = 0.
  - Then go to IDLE.
- Outside SHIFT: ser_out = 0 and ser_valid = 0.
- load_data is sampled only on the handshake edge. Changes to load_data during SHIFT have no effect.
- load_valid without load_ready is ignored: no capture, no state change, and the producer must hold the word.
- Frame length is always exactly WIDTH ser_valid cycles. There are no partial frames except on reset.
- The bit counter width is clog2(WIDTH); it must not wrap before reaching WIDTH-1.

Test Plan:
1. Reset then single word:
   - Stimulus: rst_sync 2 cycles, then load 8'hA5 with MSB_FIRST=1.
   - Response: ser_out = 1,0,1,0,0,1,0,1 over 8 cycles starting 1 cycle after the handshake; frame_start on bit 0, frame_done on bit 7; ser_valid high for exactly 8 cycles.
2. LSB-first:
   - Stimulus: MSB_FIRST=0, load 8'h01.
   - Response: ser_out = 1,0,0,0,0,0,0,0.
3. Back-to-back with GAP_CYCLES=0:
   - Stimulus: load_valid held high with 8'hFF then 8'h00.
   - Response: 16 consecutive ser_valid cycles, eight 1s then eight 0s; load_ready high in IDLE and in the last-bit cycle; frame_done at bit 7 followed immediately by frame_start.
4. Gap enforcement with GAP_CYCLES=3:
   - Stimulus: two words offered continuously.
   - Response: after frame_done, 3 cycles with ser_valid=0 and load_ready=0, then 1 IDLE cycle with load_ready=1 before the second frame starts.
5. Reset mid-frame:
   - Stimulus: assert rst_sync for 1 cycle after bit 3 of 8'hC3.
   - Response: on the next cycle all outputs are 0 and no frame_done occurs; load_ready=1 in the first cycle after rst_sync deasserts; a new word then transmits correctly.
6. Data stability:
   - Stimulus: change load_data every cycle during SHIFT while load_valid=1.
   - Response: the transmitted bits equal the word captured at the handshake; load_ready stays 0 in SHIFT (except the last-bit case when GAP_CYCLES=0).
